// File: rtl/add_arb_pkg.sv
// Shared types and constants for the add_arbiter block: datapath width,
// 32-bit saturation limits and the output-stage state encoding.
package add_arb_pkg;

  localparam int W = 32;

  localparam logic [W-1:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [W-1:0] SAT_NEG = 32'h8000_0000;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/qadd.sv
// Combinational 32-bit signed saturating adder; o_sat flags a clamped sum.
module qadd
  import add_arb_pkg::*;
(
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_sat
);

  logic [W-1:0] raw;
  logic         pos_ovf;
  logic         neg_ovf;

  always_comb begin
    raw     = i_a + i_b;
    // Overflow is only possible when both operands share a sign the sum lost.
    pos_ovf = ~i_a[W-1] & ~i_b[W-1] &  raw[W-1];
    neg_ovf =  i_a[W-1] &  i_b[W-1] & ~raw[W-1];
    o_sat   = pos_ovf | neg_ovf;
    if (pos_ovf) begin
      o_sum = SAT_POS;
    end else if (neg_ovf) begin
      o_sum = SAT_NEG;
    end else begin
      o_sum = raw;
    end
  end

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after i_ptr, wrapping N-1 -> 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // One spare bit so ptr + offset never wraps before the modulo fold.
  logic [IW:0]   cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    o_gnt    = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, i_ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      cand_idx = cand[IW-1:0];
      if (!o_any && i_req[cand_idx]) begin
        o_any           = 1'b1;
        o_idx           = cand_idx;
        o_gnt[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// N_REQ requesters share one saturating adder through a round-robin arbiter
// feeding a one-entry result register. Optional macro: ADD_ARBITER_SAT_CNT_EN.
module add_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int W     = add_arb_pkg::W,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ-1:0][W-1:0] i_a,
  input  logic [N_REQ-1:0][W-1:0] i_b,
  output logic [N_REQ-1:0]        o_gnt,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [W-1:0]            o_result,
  output logic [IW-1:0]           o_id,
  output logic                    o_sat,
  output logic [15:0]             o_sat_cnt
);

  import add_arb_pkg::*;

  // Handshake: a result transfers on any edge with o_valid && i_ready; o_valid
  // never drops and o_result/o_id/o_sat never change while waiting for i_ready.

  out_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [W-1:0]  result_q, result_d;
  logic          sat_q, sat_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             grant;
  logic [W-1:0]     win_a, win_b;
  logic [W-1:0]     sum;
  logic             sum_sat;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .i_req (i_req),
    .i_ptr (ptr_q),
    .o_gnt (pick_gnt),
    .o_idx (pick_idx),
    .o_any (pick_any)
  );

  qadd u_qadd (
    .i_a   (win_a),
    .i_b   (win_b),
    .o_sum (sum),
    .o_sat (sum_sat)
  );

  always_comb begin
    // The slot is free when empty or when the held result drains this edge.
    grant = i_rst_n && pick_any && ((state_q == OUT_EMPTY) || i_ready);
    o_gnt = grant ? pick_gnt : '0;
    win_a = i_a[pick_idx];
    win_b = i_b[pick_idx];
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    result_d = result_q;
    id_d     = id_q;
    sat_d    = sat_q;
    if (grant) begin
      state_d  = OUT_FULL;
      result_d = sum;
      id_d     = pick_idx;
      sat_d    = sum_sat;
      ptr_d    = (pick_idx == IW'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
    end else if ((state_q == OUT_FULL) && i_ready) begin
      state_d = OUT_EMPTY;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= OUT_EMPTY;
      ptr_q    <= '0;
      result_q <= '0;
      id_q     <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      result_q <= result_d;
      id_q     <= id_d;
      sat_q    <= sat_d;
    end
  end

  assign o_valid  = (state_q == OUT_FULL);
  assign o_result = result_q;
  assign o_id     = id_q;
  assign o_sat    = sat_q;

`ifdef ADD_ARBITER_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    // Saturating event counter: sticks at all-ones instead of wrapping.
    if (grant && sum_sat && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign o_sat_cnt = sat_cnt_q;
`else
  assign o_sat_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural arbitration/saturation model.
module tb_add_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        req;
  logic [N-1:0][W-1:0] a;
  logic [N-1:0][W-1:0] b;
  logic                ready;
  logic [N-1:0]        gnt;
  logic                valid;
  logic [W-1:0]        result;
  logic [1:0]          id;
  logic                sat;
  logic [15:0]         sat_cnt;

  always #5 clk = ~clk;

  add_arbiter #(.N_REQ(N), .W(W)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .i_a       (a),
    .i_b       (b),
    .o_gnt     (gnt),
    .o_valid   (valid),
    .i_ready   (ready),
    .o_result  (result),
    .o_id      (id),
    .o_sat     (sat),
    .o_sat_cnt (sat_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  int           m_ptr;
  bit           m_full;
  logic [W-1:0] m_result;
  int           m_id;
  bit           m_sat;
  int           m_cnt;
  logic [W-1:0] exp_q[$];

  function automatic void model_reset();
    m_ptr    = 0;
    m_full   = 1'b0;
    m_result = '0;
    m_id     = 0;
    m_sat    = 1'b0;
    m_cnt    = 0;
    exp_q.delete();
  endfunction

  // True arithmetic sum in 64 bits, then clamp to the signed 32-bit range.
  function automatic void sat_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] s, output bit c);
    longint t;
    t = longint'($signed(x)) + longint'($signed(y));
    if (t > 64'sd2147483647) begin
      s = 32'h7FFF_FFFF;
      c = 1'b1;
    end else if (t < -64'sd2147483648) begin
      s = 32'h8000_0000;
      c = 1'b1;
    end else begin
      s = t[31:0];
      c = 1'b0;
    end
  endfunction

  function automatic int model_winner(input logic [N-1:0] r, input logic rdy);
    int k;
    if (m_full && !rdy) return -1;
    for (int i = 0; i < N; i++) begin
      k = (m_ptr + i) % N;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] gvec(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic model_edge(input int g, input logic rdy);
    logic [W-1:0] s;
    bit           c;
    if (g >= 0) begin
      sat_add(a[g], b[g], s, c);
      m_result = s;
      m_sat    = c;
      m_id     = g;
      m_full   = 1'b1;
      m_ptr    = (g + 1) % N;
`ifdef ADD_ARBITER_SAT_CNT_EN
      if (c && m_cnt < 65535) m_cnt++;
`endif
      exp_q.push_back(s);
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [N-1:0] r, input logic rdy,
                       output logic [N-1:0] g_obs, output logic [N-1:0] g_exp);
    int g;
    @(negedge clk);
    req   = r;
    ready = rdy;
    #1;
    g_obs = gnt;
    g     = model_winner(r, rdy);
    g_exp = gvec(g);
    model_edge(g, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return 32'h7FFF_0000 + 32'($urandom_range(0, 16'hFFFF));
      1:       return 32'h8000_0000 + 32'($urandom_range(0, 16'hFFFF));
      default: return $urandom();
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid); end
    n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_tests++; if (id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", id); end
    n_tests++; if (sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %0b want 0", sat); end
    n_tests++; if (sat_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_sat_cnt: got %0d want 0", sat_cnt); end
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt_gated: got %b want 0000", gnt); end
    @(negedge clk);
    req   = '0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    logic [N-1:0] go, ge;
    a[0] = 32'd5;
    b[0] = 32'd7;
    cycle(4'b0001, 1'b1, go, ge);
    n_tests++; if (go !== 4'b0001) begin n_fail++; $display("FAIL basic_gnt: got %b want 0001", go); end
    @(posedge clk); #1;
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b want 1", valid); end
    n_tests++; if (result !== 32'd12) begin n_fail++; $display("FAIL basic_result: got %0d want 12", result); end
    n_tests++; if (id !== 2'd0) begin n_fail++; $display("FAIL basic_id: got %0d want 0", id); end
    n_tests++; if (sat !== 1'b0) begin n_fail++; $display("FAIL basic_sat: got %0b want 0", sat); end
    cycle(4'b0000, 1'b1, go, ge);
    n_tests++; if (go !== 4'b0000) begin n_fail++; $display("FAIL basic_gnt_idle: got %b want 0000", go); end
    @(posedge clk); #1;
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %0b want 0", valid); end
  endtask

  task automatic test_saturation();
    logic [N-1:0] go, ge;
    logic [15:0]  exp_cnt;
    a[1] = 32'h7FFF_FFF0;
    b[1] = 32'h0000_0020;
    cycle(4'b0010, 1'b1, go, ge);
    n_tests++; if (go !== 4'b0010) begin n_fail++; $display("FAIL satpos_gnt: got %b want 0010", go); end
    @(posedge clk); #1;
    n_tests++; if (result !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL satpos_result: got %h want 7fffffff", result); end
    n_tests++; if (sat !== 1'b1) begin n_fail++; $display("FAIL satpos_flag: got %0b want 1", sat); end
    a[2] = 32'h8000_0001;
    b[2] = 32'hFFFF_FFF0;
    cycle(4'b0100, 1'b1, go, ge);
    @(posedge clk); #1;
    n_tests++; if (result !== 32'h8000_0000) begin n_fail++; $display("FAIL satneg_result: got %h want 80000000", result); end
    n_tests++; if (sat !== 1'b1) begin n_fail++; $display("FAIL satneg_flag: got %0b want 1", sat); end
    n_tests++; if (id !== 2'd2) begin n_fail++; $display("FAIL satneg_id: got %0d want 2", id); end
    a[3] = 32'hFFFF_FFFE;
    b[3] = 32'hFFFF_FFFD;
    cycle(4'b1000, 1'b1, go, ge);
    @(posedge clk); #1;
    n_tests++; if (result !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL negsum_result: got %h want fffffffb", result); end
    n_tests++; if (sat !== 1'b0) begin n_fail++; $display("FAIL negsum_flag: got %0b want 0", sat); end
    cycle(4'b0000, 1'b1, go, ge);
    @(posedge clk); #1;
`ifdef ADD_ARBITER_SAT_CNT_EN
    exp_cnt = 16'd2;
`else
    exp_cnt = 16'd0;
`endif
    n_tests++; if (sat_cnt !== exp_cnt) begin n_fail++; $display("FAIL sat_cnt: got %0d want %0d", sat_cnt, exp_cnt); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] go, ge;
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) begin
      a[i] = 32'(i * 100);
      b[i] = 32'd1;
    end
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 1'b1, go, ge);
      n_tests++; if (go !== gvec(order[i])) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, go, gvec(order[i])); end
      @(posedge clk); #1;
      n_tests++; if (id !== 2'(order[i])) begin n_fail++; $display("FAIL rr_id[%0d]: got %0d want %0d", i, id, order[i]); end
      n_tests++; if (result !== 32'(order[i] * 100 + 1)) begin n_fail++; $display("FAIL rr_result[%0d]: got %0d want %0d", i, result, order[i] * 100 + 1); end
    end
    cycle(4'b0000, 1'b1, go, ge);
  endtask

  task automatic test_backpressure();
    logic [N-1:0] go, ge;
    do_reset();
    a[0] = 32'd5;
    b[0] = 32'd7;
    cycle(4'b0001, 1'b1, go, ge);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b1111, 1'b0, go, ge);
      n_tests++; if (go !== 4'b0000) begin n_fail++; $display("FAIL bp_gnt[%0d]: got %b want 0000", i, go); end
      @(posedge clk); #1;
      n_tests++; if (valid !== 1'b1 || result !== 32'd12 || id !== 2'd0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%0b r=%0d id=%0d want v=1 r=12 id=0", i, valid, result, id);
      end
    end
    cycle(4'b1111, 1'b1, go, ge);
    n_tests++; if (go !== 4'b0010) begin n_fail++; $display("FAIL bp_release_gnt: got %b want 0010", go); end
    @(posedge clk); #1;
    n_tests++; if (result !== m_result || id !== 2'(m_id)) begin
      n_fail++; $display("FAIL bp_release_result: got r=%h id=%0d want r=%h id=%0d", result, id, m_result, m_id);
    end
    cycle(4'b0000, 1'b1, go, ge);
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] go, ge;
    cycle(4'b0100, 1'b0, go, ge);
    @(posedge clk); #1;
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL mid_full: got %0b want 1", valid); end
    #2;
    rst_n = 1'b0;
    req   = '0;
    #1;
    n_tests++; if (valid !== 1'b0 || result !== 32'h0) begin
      n_fail++; $display("FAIL mid_async_clear: got v=%0b r=%h want v=0 r=0", valid, result);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b0000, 1'b1, go, ge);
    n_tests++; if (go !== 4'b0000) begin n_fail++; $display("FAIL mid_no_req_gnt: got %b want 0000", go); end
    cycle(4'b1111, 1'b1, go, ge);
    n_tests++; if (go !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr_restart: got %b want 0001", go); end
    @(posedge clk); #1;
    n_tests++; if (id !== 2'd0) begin n_fail++; $display("FAIL mid_id: got %0d want 0", id); end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    int           g;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      req   = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++) begin
        a[i] = rand_op();
        b[i] = rand_op();
      end
      #1;
      if (valid && ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_sb[%0d]: got accepted result %h want no result pending", c, result);
        end else begin
          e = exp_q.pop_front();
          if (result !== e) begin n_fail++; $display("FAIL rnd_sb[%0d]: got %h want %h", c, result, e); end
        end
      end
      g = model_winner(req, ready);
      n_tests++; if (gnt !== gvec(g)) begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %b want %b", c, gnt, gvec(g)); end
      model_edge(g, ready);
      @(posedge clk); #1;
      n_tests++; if (valid !== m_full) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", c, valid, m_full); end
      if (m_full) begin
        n_tests++; if (result !== m_result || id !== 2'(m_id) || sat !== m_sat) begin
          n_fail++; $display("FAIL rnd_out[%0d]: got r=%h id=%0d s=%0b want r=%h id=%0d s=%0b",
                             c, result, id, sat, m_result, m_id, m_sat);
        end
      end
      n_tests++; if (sat_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", c, sat_cnt, m_cnt); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    ready = 1'b1;
    a     = '0;
    b     = '0;
    model_reset();
    test_reset();
    test_basic();
    test_saturation();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the adder (2..8).
REQ-002 Parameter W, default 32, operand/result width; fixed at 32, matching the shared saturating adder.
REQ-003 i_clk  input  1  single clock; all state on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_req  input  N_REQ  per-requester request; held with operands until granted.
REQ-006 i_a, i_b  input  N_REQ x W  per-requester signed two's-complement operands.
REQ-007 o_gnt  output  N_REQ  one-hot, one-cycle pulse: operands of that requester captured this edge.
REQ-008 o_valid  output  1  result register holds a result.
REQ-009 i_ready  input  1  consumer accepts result when o_valid && i_ready.
REQ-010 o_result  output  W  saturated sum.
REQ-011 o_id  output  clog2(N_REQ)  index of requester owning o_result.
REQ-012 o_sat  output  1  result was clamped (positive or negative).
REQ-013 o_sat_cnt  output  16  saturation event count (see Configuration).

Function
REQ-014 Output stage SHALL be a two-state FSM: EMPTY (o_valid=0), FULL (o_valid=1).
REQ-015 A grant SHALL be issued in a cycle iff some i_req bit is set and (state==EMPTY or i_ready==1).
REQ-016 Winner SHALL be chosen round-robin: first requesting index at or after pointer ptr, wrapping N_REQ-1 -> 0.
REQ-017 After a grant to index k, ptr SHALL become (k+1) mod N_REQ; with no grant ptr SHALL hold.
REQ-018 o_gnt SHALL be combinational from current i_req, ptr, state, i_ready; at most one bit set.
REQ-019 On the grant edge, result register SHALL load saturated sum of i_a[k]+i_b[k], o_id=k, o_sat; state -> FULL; latency one cycle from grant to o_valid.
REQ-020 Saturation: both operands negative and raw sum non-negative -> 0x80000000; both non-negative and raw sum negative -> 0x7FFFFFFF; else wrapped raw sum; o_sat=1 only when clamped.
REQ-021 FULL with i_ready=1 and a grant SHALL reload back-to-back (throughput one result/cycle); FULL with i_ready=1 and no grant -> EMPTY.
REQ-022 FULL with i_ready=0 SHALL hold o_result, o_id, o_sat stable and issue no grant.
REQ-023 A requester deasserting i_req before grant SHALL simply lose the arbitration; no error state.

Reset
REQ-024 While i_rst_n=0: state EMPTY, o_valid=0, o_result=0, o_id=0, o_sat=0, ptr=0, o_sat_cnt=0, o_gnt=0 (grant gated by reset).
REQ-025 Reset asserted mid-operation SHALL discard any held result; no grant in the first edge after release unless i_req set.

Configuration
REQ-026 Macro ADD_ARBITER_SAT_CNT_EN defined: o_sat_cnt SHALL increment on each grant edge whose result has o_sat=1, sticking at 0xFFFF.
REQ-027 Macro undefined: counter logic absent, o_sat_cnt tied to 0.

Structure
REQ-028 Shared package add_arb_pkg SHALL hold W, the 32-bit positive/negative saturation constants, and the output-state enum.
REQ-029 Summation SHALL use one instance of the team's combinational saturating adder qadd fed by the winner mux; round-robin picker SHALL be sub-module rr_pick (inputs req, ptr; outputs one-hot gnt, index, any).

Verification
REQ-030 Req 0 only, a=5, b=7, i_ready=1 -> o_gnt=0001 one cycle, next cycle o_valid=1, o_result=12, o_id=0, o_sat=0.
REQ-031 a=0x7FFFFFF0, b=0x20 -> o_result=0x7FFFFFFF, o_sat=1; a=0x80000001, b=0xFFFFFFF0 -> 0x80000000, o_sat=1; o_sat_cnt=2 with macro, 0 without.
REQ-032 All four requesting continuously, i_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, o_id follows one cycle later.
REQ-033 i_ready=0 for 5 cycles with result 12 held -> o_result stable, o_gnt=0 throughout; i_ready=1 -> next grant same cycle.
REQ-034 Assert i_rst_n=0 while FULL -> o_valid=0, o_result=0 immediately (asynchronous), ptr restarts at 0.
